// File: rtl/fifo_prog.sv
// fifo_prog: single-clock parametrised FIFO with a compile-time read mode
// (registered read or first-word-fall-through), programmable almost-full and
// almost-empty thresholds, a fill-level output, and sticky error status.
//
// Ports:
//   clk, reset_n          rising-edge clock, asynchronous active-low reset
//   write_en, data_in     push request and its data
//   read_en               pop request
//   af_thresh, ae_thresh  almost-full / almost-empty thresholds (quasi-static)
//   err_clr               clears ovf_sticky / udf_sticky (a new error wins)
//   data_out, data_valid  read data and its qualifier
//   full, empty           level == DEPTH / level == 0
//   almost_full           level >= af_thresh (forced high when af_thresh == 0)
//   almost_empty          level <= ae_thresh
//   level                 number of stored entries, 0..DEPTH
//   overflow, underflow   one-cycle pulses after a rejected write / read
//   ovf_sticky, udf_sticky latched error status
module fifo_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_en,
  input  logic                  read_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ovf_sticky,
  output logic                  udf_sticky
);

  localparam logic [ADDR_WIDTH:0]   LVL_MAX  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  wr_rej;
  logic                  rd_rej;

  assign full  = (level == LVL_MAX);
  assign empty = (level == '0);

  // A read never becomes legal because of a same-cycle write into an empty
  // FIFO, but a write into a full FIFO is legal when a read frees a slot.
  assign rd_acc = read_en && !empty;
  assign wr_acc = write_en && (!full || rd_acc);
  assign wr_rej = write_en && !wr_acc;
  assign rd_rej = read_en && !rd_acc;

  assign almost_full  = (af_thresh == '0) || (level >= af_thresh);
  assign almost_empty = (level <= ae_thresh);

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
      ovf_sticky <= 1'b0;
      udf_sticky <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      overflow  <= wr_rej;
      underflow <= rd_rej;
      if (wr_rej) begin
        ovf_sticky <= 1'b1;
      end else if (err_clr) begin
        ovf_sticky <= 1'b0;
      end
      if (rd_rej) begin
        udf_sticky <= 1'b1;
      end else if (err_clr) begin
        udf_sticky <= 1'b0;
      end
    end
  end

  if (FWFT != 0) begin : g_fwft
    // hold_q tracks the head shown while non-empty, so data_out keeps the
    // last presented word once the FIFO drains.
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        hold_q <= '0;
      end else if (!empty) begin
        hold_q <= mem[rd_ptr];
      end
    end

    assign data_out   = empty ? hold_q : mem[rd_ptr];
    assign data_valid = !empty;
  end else begin : g_std
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        data_out   <= '0;
        data_valid <= 1'b0;
      end else begin
        data_valid <= rd_acc;
        if (rd_acc) begin
          data_out <= mem[rd_ptr];
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_prog.sv
// tb_fifo_prog: directed and randomized bench for fifo_prog. Three instances:
// A = DEPTH 16 standard, B = DEPTH 5 standard, C = DEPTH 4 FWFT. A queue-based
// reference model per instance predicts every output after each clock step.
module tb_fifo_prog;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_we, a_re, a_clr, a_dv, a_full, a_empty, a_afl, a_ael, a_ovf, a_udf, a_os, a_us;
  logic [7:0] a_din, a_dout;
  logic [4:0] a_af, a_ae, a_lvl;
  logic       b_we, b_re, b_clr, b_dv, b_full, b_empty, b_afl, b_ael, b_ovf, b_udf, b_os, b_us;
  logic [7:0] b_din, b_dout;
  logic [3:0] b_af, b_ae, b_lvl;
  logic       c_we, c_re, c_clr, c_dv, c_full, c_empty, c_afl, c_ael, c_ovf, c_udf, c_os, c_us;
  logic [7:0] c_din, c_dout;
  logic [2:0] c_af, c_ae, c_lvl;

  fifo_prog #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .reset_n(reset_n), .write_en(a_we), .read_en(a_re), .data_in(a_din),
    .af_thresh(a_af), .ae_thresh(a_ae), .err_clr(a_clr), .data_out(a_dout),
    .data_valid(a_dv), .full(a_full), .empty(a_empty), .almost_full(a_afl),
    .almost_empty(a_ael), .level(a_lvl), .overflow(a_ovf), .underflow(a_udf),
    .ovf_sticky(a_os), .udf_sticky(a_us));

  fifo_prog #(.DATA_WIDTH(8), .DEPTH(5), .FWFT(0)) u_b (
    .clk(clk), .reset_n(reset_n), .write_en(b_we), .read_en(b_re), .data_in(b_din),
    .af_thresh(b_af), .ae_thresh(b_ae), .err_clr(b_clr), .data_out(b_dout),
    .data_valid(b_dv), .full(b_full), .empty(b_empty), .almost_full(b_afl),
    .almost_empty(b_ael), .level(b_lvl), .overflow(b_ovf), .underflow(b_udf),
    .ovf_sticky(b_os), .udf_sticky(b_us));

  fifo_prog #(.DATA_WIDTH(8), .DEPTH(4), .FWFT(1)) u_c (
    .clk(clk), .reset_n(reset_n), .write_en(c_we), .read_en(c_re), .data_in(c_din),
    .af_thresh(c_af), .ae_thresh(c_ae), .err_clr(c_clr), .data_out(c_dout),
    .data_valid(c_dv), .full(c_full), .empty(c_empty), .almost_full(c_afl),
    .almost_empty(c_ael), .level(c_lvl), .overflow(c_ovf), .underflow(c_udf),
    .ovf_sticky(c_os), .udf_sticky(c_us));

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];
  int         depth_of[3] = '{16, 5, 4};
  int         tmax[3]     = '{31, 15, 7};
  int         m_af[3];
  int         m_ae[3];
  logic [7:0] m_dout[3];
  bit         m_dv[3], m_ovf[3], m_udf[3], m_os[3], m_us[3];

  function automatic int qsize(input int id);
    case (id)
      0:       return qa.size();
      1:       return qb.size();
      default: return qc.size();
    endcase
  endfunction

  function automatic logic [7:0] qfront(input int id);
    case (id)
      0:       return qa[0];
      1:       return qb[0];
      default: return qc[0];
    endcase
  endfunction

  task automatic qpush(input int id, input logic [7:0] d);
    case (id)
      0:       qa.push_back(d);
      1:       qb.push_back(d);
      default: qc.push_back(d);
    endcase
  endtask

  task automatic qpop(input int id);
    case (id)
      0:       void'(qa.pop_front());
      1:       void'(qb.pop_front());
      default: void'(qc.pop_front());
    endcase
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    qc.delete();
    for (int i = 0; i < 3; i++) begin
      m_dout[i] = 8'h00;
      m_dv[i]   = 1'b0;
      m_ovf[i]  = 1'b0;
      m_udf[i]  = 1'b0;
      m_os[i]   = 1'b0;
      m_us[i]   = 1'b0;
    end
  endtask

  // One clock edge of the FIFO rules, applied to the pre-edge state.
  task automatic model(input int id, input bit we, input bit re, input bit clr,
                       input logic [7:0] din);
    int n;
    bit rd_ok;
    bit wr_ok;
    n     = qsize(id);
    rd_ok = re && (n > 0);
    wr_ok = we && ((n < depth_of[id]) || rd_ok);
    m_ovf[id] = we && !wr_ok;
    m_udf[id] = re && !rd_ok;
    if (id == 2) begin
      if (rd_ok) qpop(id);
      if (wr_ok) qpush(id, din);
      m_dv[id] = (qsize(id) > 0);
      if (qsize(id) > 0) m_dout[id] = qfront(id);
    end else begin
      m_dv[id] = rd_ok;
      if (rd_ok) begin
        m_dout[id] = qfront(id);
        qpop(id);
      end
      if (wr_ok) qpush(id, din);
    end
    m_os[id] = m_ovf[id] ? 1'b1 : (clr ? 1'b0 : m_os[id]);
    m_us[id] = m_udf[id] ? 1'b1 : (clr ? 1'b0 : m_us[id]);
  endtask

  task automatic chk(input int id, input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL dut%0d %s observed=%0h expected=%0h", id, tag, obs, exp);
    end
  endtask

  task automatic drive(input int id, input bit we, input bit re, input bit clr,
                       input logic [7:0] din);
    case (id)
      0: begin a_we = we; a_re = re; a_clr = clr; a_din = din; end
      1: begin b_we = we; b_re = re; b_clr = clr; b_din = din; end
      default: begin c_we = we; c_re = re; c_clr = clr; c_din = din; end
    endcase
  endtask

  task automatic set_thresh(input int id, input int af, input int ae);
    m_af[id] = af;
    m_ae[id] = ae;
    case (id)
      0: begin a_af = 5'(af); a_ae = 5'(ae); end
      1: begin b_af = 4'(af); b_ae = 4'(ae); end
      default: begin c_af = 3'(af); c_ae = 3'(ae); end
    endcase
  endtask

  task automatic check_all(input int id);
    logic [31:0] o_lvl, o_dout;
    logic        o_dv, o_full, o_empty, o_afl, o_ael, o_ovf, o_udf, o_os, o_us;
    int          n;
    case (id)
      0: begin
        o_lvl = 32'(a_lvl); o_dout = 32'(a_dout); o_dv = a_dv; o_full = a_full;
        o_empty = a_empty; o_afl = a_afl; o_ael = a_ael; o_ovf = a_ovf;
        o_udf = a_udf; o_os = a_os; o_us = a_us;
      end
      1: begin
        o_lvl = 32'(b_lvl); o_dout = 32'(b_dout); o_dv = b_dv; o_full = b_full;
        o_empty = b_empty; o_afl = b_afl; o_ael = b_ael; o_ovf = b_ovf;
        o_udf = b_udf; o_os = b_os; o_us = b_us;
      end
      default: begin
        o_lvl = 32'(c_lvl); o_dout = 32'(c_dout); o_dv = c_dv; o_full = c_full;
        o_empty = c_empty; o_afl = c_afl; o_ael = c_ael; o_ovf = c_ovf;
        o_udf = c_udf; o_os = c_os; o_us = c_us;
      end
    endcase
    n = qsize(id);
    chk(id, "level", o_lvl, 32'(n));
    chk(id, "full", 32'(o_full), 32'(n == depth_of[id]));
    chk(id, "empty", 32'(o_empty), 32'(n == 0));
    chk(id, "almost_full", 32'(o_afl), 32'((m_af[id] == 0) || (n >= m_af[id])));
    chk(id, "almost_empty", 32'(o_ael), 32'(n <= m_ae[id]));
    chk(id, "data_out", o_dout, 32'(m_dout[id]));
    chk(id, "data_valid", 32'(o_dv), 32'(m_dv[id]));
    chk(id, "overflow", 32'(o_ovf), 32'(m_ovf[id]));
    chk(id, "underflow", 32'(o_udf), 32'(m_udf[id]));
    chk(id, "ovf_sticky", 32'(o_os), 32'(m_os[id]));
    chk(id, "udf_sticky", 32'(o_us), 32'(m_us[id]));
  endtask

  task automatic step(input int id, input bit we, input bit re, input bit clr,
                      input logic [7:0] din);
    @(negedge clk);
    drive(id, we, re, clr, din);
    @(posedge clk);
    model(id, we, re, clr, din);
    #1;
    drive(id, 1'b0, 1'b0, 1'b0, 8'h00);
    check_all(id);
  endtask

  // Asynchronous assertion mid-cycle: outputs must clear before any edge.
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) check_all(i);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b0, 8'h00);
    set_thresh(0, 14, 2);
    set_thresh(1, 4, 1);
    set_thresh(2, 3, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) check_all(i);
    @(negedge clk);
    reset_n = 1'b1;

    // Fill A with 0x00..0x0F
    for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, 1'b0, 8'(i));

    // Overflow, sticky hold, set-wins-over-clear, then clear
    step(0, 1'b1, 1'b0, 1'b0, 8'hAA);
    step(0, 1'b0, 1'b0, 1'b0, 8'h00);
    step(0, 1'b1, 1'b0, 1'b1, 8'hAB);
    step(0, 1'b0, 1'b0, 1'b1, 8'h00);
    step(0, 1'b0, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Underflow with simultaneous write into empty
    step(0, 1'b1, 1'b1, 1'b0, 8'h55);
    step(0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(0, 1'b0, 1'b0, 1'b1, 8'h00);

    // Full with concurrent read and write
    for (int i = 0; i < 16; i++) step(0, 1'b1, 1'b0, 1'b0, 8'(i));
    step(0, 1'b1, 1'b1, 1'b0, 8'h77);
    for (int i = 0; i < 16; i++) step(0, 1'b0, 1'b1, 1'b0, 8'h00);

    // Threshold boundaries: af=0 forces almost_full, ae>=DEPTH forces almost_empty
    set_thresh(0, 0, 16);
    step(0, 1'b1, 1'b0, 1'b0, 8'h01);
    set_thresh(0, 16, 31);
    step(0, 1'b0, 1'b1, 1'b0, 8'h00);
    set_thresh(0, 14, 2);

    // B (DEPTH=5): 23 streamed words at level <= 3 across pointer wraps
    for (int k = 0; k < 3; k++) step(1, 1'b1, 1'b0, 1'b0, 8'(8'h10 + k));
    for (int k = 3; k < 23; k++) step(1, 1'b1, 1'b1, 1'b0, 8'(8'h10 + k));
    for (int k = 0; k < 3; k++) step(1, 1'b0, 1'b1, 1'b0, 8'h00);

    // C (FWFT): head visible before read_en, pop back to empty
    step(2, 1'b1, 1'b0, 1'b0, 8'h3C);
    step(2, 1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) step(2, 1'b1, 1'b0, 1'b0, 8'(8'hC0 + k));
    step(2, 1'b1, 1'b1, 1'b0, 8'hD0);
    for (int k = 0; k < 5; k++) step(2, 1'b0, 1'b1, 1'b0, 8'h00);

    // Randomized traffic on every instance, write-heavy then read-heavy
    for (int id = 0; id < 3; id++) begin
      for (int c = 0; c < 400; c++) begin
        int wp;
        if (c % 80 == 0)
          set_thresh(id, int'($urandom_range(0, depth_of[id])), int'($urandom_range(0, tmax[id])));
        wp = ((c / 100) % 2 == 0) ? 70 : 30;
        step(id, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
             $urandom_range(0, 9) == 0, 8'($urandom));
      end
    end

    // Reset mid-operation discards stored data
    for (int k = 0; k < 4; k++) step(0, 1'b1, 1'b0, 1'b0, 8'(8'hE0 + k));
    for (int k = 0; k < 2; k++) step(2, 1'b1, 1'b0, 1'b0, 8'(8'hF0 + k));
    do_reset();
    step(0, 1'b0, 1'b1, 1'b0, 8'h00);
    step(2, 1'b1, 1'b0, 1'b0, 8'h99);
    step(0, 1'b1, 1'b0, 1'b0, 8'h42);
    step(0, 1'b0, 1'b1, 1'b0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_prog.md
# fifo_prog

Parametrised synchronous FIFO, successor to the fixed single-mode `fifo`. It adds a compile-time read mode (standard registered read or first-word-fall-through), runtime-programmable almost-full/almost-empty thresholds, a fill-level output, and sticky error status with clear. It sits between producer and consumer logic in one clock domain and drops into existing benches through the same `write_en`/`read_en`/flag interface.

## Interface
- `DATA_WIDTH`, 8: data word width in bits, ≥1.
- `DEPTH`, 16: number of entries, ≥2; need not be a power of two.
- `FWFT`, 0: 0 = standard read mode, 1 = first-word-fall-through.
- `ADDR_WIDTH`, `$clog2(DEPTH)`: pointer width; derived, not overridden.
- `clk` input 1: single clock; all logic on rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `write_en` input 1: push request.
- `read_en` input 1: pop request.
- `data_in` input DATA_WIDTH: write data.
- `af_thresh` input ADDR_WIDTH+1: almost-full threshold, quasi-static.
- `ae_thresh` input ADDR_WIDTH+1: almost-empty threshold, quasi-static.
- `err_clr` input 1: clears the sticky error bits.
- `data_out` output DATA_WIDTH: read data.
- `data_valid` output 1: `data_out` holds a valid popped (standard) or head (FWFT) word.
- `full`, `empty` output 1: level == DEPTH / level == 0.
- `almost_full` output 1: level ≥ `af_thresh`.
- `almost_empty` output 1: level ≤ `ae_thresh`.
- `level` output ADDR_WIDTH+1: entries stored, 0..DEPTH.
- `overflow`, `underflow` output 1: one-cycle pulses for a rejected write or read.
- `ovf_sticky`, `udf_sticky` output 1: latched error status.

## Operation
- Storage: DEPTH×DATA_WIDTH array. Write and read pointers run 0..DEPTH-1 and wrap to 0 explicitly. `level` is a registered counter, not a pointer difference.
- Write accepted when `write_en` and (!full, or read accepted in the same cycle). Rejected write: data dropped, `overflow` pulses, nothing else changes.
- Read accepted when `read_en` and !empty. A simultaneous write into an empty FIFO does not make the read legal. Rejected read: `underflow` pulses, `data_out` holds its value.
- Level update: +1 for write only, −1 for read only, unchanged for both or neither.
- Standard mode: on an accepted read, `data_out` is loaded from the head on that edge and `data_valid` is 1 for the following cycle only. Otherwise `data_out` holds and `data_valid` is 0.
- FWFT mode: `data_out` shows the head entry whenever !empty, and `data_valid` = !empty. An accepted `read_en` pops, and the next entry (if any) is on `data_out` after the edge. When empty, `data_out` holds its last value.
- Flags are combinational from registered `level` and the thresholds. `af_thresh` = 0 forces `almost_full` to 1. `ae_thresh` ≥ DEPTH forces `almost_empty` to 1.
- Sticky bits: set on the edge where the matching pulse is generated, and cleared by `err_clr`. If set and clear occur in the same cycle, set wins.

## Timing
- Reset (asynchronous assert, synchronous release on the next edge): pointers 0, `level` 0, `empty` 1, `full` 0, `almost_empty` 1, `almost_full` = (`af_thresh` == 0), `data_out` 0, `data_valid` 0, `overflow`/`underflow` 0, sticky bits 0. Memory contents are not reset.
- Reset mid-operation discards all stored data immediately. There is no pending pop completion.
- Write at edge N: `level`, `empty`, and the FWFT `data_out` update after edge N (one cycle).
- Standard read latency: `read_en` sampled at edge N, `data_out`/`data_valid` valid from edge N to edge N+1.
- `overflow`/`underflow` are registered and high for exactly the cycle after the offending edge.
- Throughput: one write and one read per cycle, sustained, at any level including full and wrap points.

## Test plan
- Reset and fill (DEPTH=16, FWFT=0, af=14, ae=2): write 0x00..0x0F, one per cycle. `almost_empty` drops after the 3rd write, `almost_full` rises after the 14th, `full`=1 and `level`=16 after the 16th, and there is no overflow.
- Overflow and sticky: with the FIFO full, write 0xAA with no read. `overflow` pulses once, `ovf_sticky`=1 until an `err_clr` cycle, and contents are unchanged. Draining then returns 0x00..0x0F in order, each valid one cycle after `read_en`.
- Underflow plus simultaneous write on empty: `read_en`=1, `write_en`=1, `data_in`=0x55 on the same cycle. `underflow` pulses, `level`=1, and the next read returns 0x55.
- Full with concurrent read and write: at level 16, write 0x77 while reading. Read returns 0x00, no overflow, `level` stays 16, and the last word read after draining is 0x77.
- Wrap with DEPTH=5 (non-power-of-two): 23 streamed writes and reads at level ≤3 return data in exact order, with `level` never exceeding 3.
- FWFT mode: write 0x3C to an empty FIFO. One cycle later `data_valid`=1 and `data_out`=0x3C before any `read_en`. Asserting `read_en` leaves `empty`=1 and `data_valid`=0 after the edge.
